// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared definitions for the instruction-fetch stage: default reset PC,
//   bubble encoding, FSM state encodings and a PC word-alignment helper.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] INST_NOP_DEF = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//   Architectural PC register. Load has priority over the +4 advance.
//   Ports:
//     clk      in  1   clock
//     rst      in  1   synchronous active-high reset (PcQ <= RESET_PC)
//     En       in  1   advance PcQ by 4
//     Load     in  1   load PcQ from LoadVal (wins over En)
//     LoadVal  in  32  value to load
//     PcQ      out 32  current PC
// -----------------------------------------------------------------------------
module pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        En,
  input  logic        Load,
  input  logic [31:0] LoadVal,
  output logic [31:0] PcQ
);

  logic [31:0] r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (Load) begin
      r_pc <= LoadVal;
    end else if (En) begin
      r_pc <= r_pc + 32'd4;  // modulo 2^32: 0xFFFF_FFFC wraps to 0
    end
  end

  assign PcQ = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: holds the PC, drives the IROM address, captures
//   PC / PC+4 / instruction into the IF/ID register, applies stall and
//   redirect-squash, and counts valid fetched instructions.
//   Ports:
//     clk         in  1   clock
//     rst         in  1   synchronous active-high reset
//     Npc         in  32  redirect target
//     Redirect    in  1   load Npc (word aligned), squash fetch in flight
//     Stall       in  1   hold PC, IF/ID and FetchCount
//     IromInst    in  32  combinational IROM data at IromAddr
//     IromAddr    out 32  current PC
//     IfIdPc      out 32  PC of instruction in IF/ID
//     IfIdPc4     out 32  IfIdPc + 4
//     IfIdInst    out 32  instruction in IF/ID
//     IfIdValid   out 1   IF/ID holds a real instruction
//     FetchCount  out 32  valid instructions captured into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] INST_NOP = INST_NOP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Npc,
  input  logic        Redirect,
  input  logic        Stall,
  input  logic [31:0] IromInst,
  output logic [31:0] IromAddr,
  output logic [31:0] IfIdPc,
  output logic [31:0] IfIdPc4,
  output logic [31:0] IfIdInst,
  output logic        IfIdValid,
  output logic [31:0] FetchCount
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic        w_pc_en;
  logic        w_pc_load;
  logic        w_capture;
  logic        w_bubble;
  logic [31:0] w_pc;

  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_inst;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_cnt;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .En      (w_pc_en),
    .Load    (w_pc_load),
    .LoadVal (align_pc(Npc)),
    .PcQ     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // BOOT inserts exactly one bubble and ignores Stall/Redirect/IromInst.
  // In RUN, Redirect outranks Stall.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_en     = 1'b0;
    w_pc_load   = 1'b0;
    w_capture   = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      FETCH_BOOT: begin
        w_state_nxt = FETCH_RUN;
        w_bubble    = 1'b1;
      end
      FETCH_RUN: begin
        if (Redirect) begin
          w_pc_load = 1'b1;
          w_bubble  = 1'b1;
        end else if (!Stall) begin
          w_pc_en   = 1'b1;
          w_capture = 1'b1;
        end
      end
      default: w_state_nxt = FETCH_BOOT;
    endcase
  end

  // IF/ID boundary. A bubble keeps IfIdPc/IfIdPc4 and only clears the
  // instruction and valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_pc    <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_inst  <= INST_NOP;
      r_ifid_valid <= 1'b0;
      r_fetch_cnt  <= 32'd0;
    end else if (w_bubble) begin
      r_ifid_inst  <= INST_NOP;
      r_ifid_valid <= 1'b0;
    end else if (w_capture) begin
      r_ifid_pc    <= w_pc;
      r_ifid_pc4   <= w_pc + 32'd4;
      r_ifid_inst  <= IromInst;
      r_ifid_valid <= 1'b1;
      r_fetch_cnt  <= r_fetch_cnt + 32'd1;
    end
  end

  assign IromAddr   = w_pc;
  assign IfIdPc     = r_ifid_pc;
  assign IfIdPc4    = r_ifid_pc4;
  assign IfIdInst   = r_ifid_inst;
  assign IfIdValid  = r_ifid_valid;
  assign FetchCount = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Npc;
  logic        Redirect;
  logic        Stall;
  logic [31:0] IromInst;
  logic [31:0] IromAddr;
  logic [31:0] IfIdPc;
  logic [31:0] IfIdPc4;
  logic [31:0] IfIdInst;
  logic        IfIdValid;
  logic [31:0] FetchCount;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [31:0] m_pc, m_ifpc, m_ifpc4, m_inst, m_cnt;
  logic        m_valid, m_boot;

  always #5 clk = ~clk;

  function automatic logic [31:0] irom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign IromInst = irom(IromAddr);

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .Npc        (Npc),
    .Redirect   (Redirect),
    .Stall      (Stall),
    .IromInst   (IromInst),
    .IromAddr   (IromAddr),
    .IfIdPc     (IfIdPc),
    .IfIdPc4    (IfIdPc4),
    .IfIdInst   (IfIdInst),
    .IfIdValid  (IfIdValid),
    .FetchCount (FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, compare after the edge.
  task automatic step(input logic r, input logic red, input logic [31:0] np, input logic st);
    exp_t e;
    @(negedge clk);
    rst = r; Redirect = red; Npc = np; Stall = st;
    if (r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_inst = NOP;
      m_valid = 1'b0; m_cnt = 32'h0; m_boot = 1'b1;
    end else if (m_boot) begin
      m_inst = NOP; m_valid = 1'b0; m_boot = 1'b0;
    end else if (red) begin
      m_pc = {np[31:2], 2'b00}; m_inst = NOP; m_valid = 1'b0;
    end else if (!st) begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_inst = irom(m_pc);
      m_valid = 1'b1; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
    e.addr = m_pc; e.pc = m_ifpc; e.pc4 = m_ifpc4;
    e.inst = m_inst; e.valid = m_valid; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("IromAddr",   IromAddr,          e.addr);
    chk("IfIdPc",     IfIdPc,            e.pc);
    chk("IfIdPc4",    IfIdPc4,           e.pc4);
    chk("IfIdInst",   IfIdInst,          e.inst);
    chk("IfIdValid",  {31'd0, IfIdValid}, {31'd0, e.valid});
    chk("FetchCount", FetchCount,        e.cnt);
  endtask

  initial begin
    rst = 1'b1; Redirect = 1'b0; Npc = 32'h0; Stall = 1'b0;
    m_pc = 0; m_ifpc = 0; m_ifpc4 = 0; m_inst = NOP; m_valid = 0; m_cnt = 0; m_boot = 1;

    // 1. reset, boot bubble, free run
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst_inst", IfIdInst, NOP);
    chk("rst_cnt", FetchCount, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("boot_valid", {31'd0, IfIdValid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("run_pc0", IfIdPc, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("run_pc4", IfIdPc, 32'h4);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("run_pc8", IfIdPc, 32'h8);
    chk("run_cnt3", FetchCount, 32'd3);

    // 2. stall two cycles with PcQ = 0x10
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_stall_addr", IromAddr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stall_addr", IromAddr, 32'h10);
    chk("stall_cnt", FetchCount, 32'd4);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("resume_pc", IfIdPc, 32'h10);

    // 3. redirect to an unaligned target
    step(1'b0, 1'b1, 32'h0000_0102, 1'b0);
    chk("redir_addr", IromAddr, 32'h100);
    chk("redir_valid", {31'd0, IfIdValid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("redir_cap", IfIdPc, 32'h100);

    // 4. redirect and stall together
    step(1'b0, 1'b1, 32'h200, 1'b1);
    chk("redst_addr", IromAddr, 32'h200);
    chk("redst_valid", {31'd0, IfIdValid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // 5. PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_pc", IfIdPc, 32'hFFFF_FFFC);
    chk("wrap_pc4", IfIdPc4, 32'h0);
    chk("wrap_addr", IromAddr, 32'h0);

    // mixed random traffic
    for (int i = 0; i < 40; i++) begin
      step(1'b0, ($urandom_range(7) == 0), $urandom, ($urandom_range(3) == 0));
    end

    // 6. reset while running at FetchCount=5, PcQ=0x40; boot ignores Stall
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h2C, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_cnt", FetchCount, 32'd5);
    chk("pre_rst_addr", IromAddr, 32'h40);
    step(1'b1, 1'b1, 32'h300, 1'b1);
    chk("mid_rst_addr", IromAddr, 32'h0);
    chk("mid_rst_pc", IfIdPc, 32'h0);
    chk("mid_rst_cnt", FetchCount, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("boot2_valid", {31'd0, IfIdValid}, 32'd0);
    chk("boot2_addr", IromAddr, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("boot2_cap", IfIdPc4, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
